led_trace_capture: RTL

Synthesizable change-capture block for the Briskv SoC. It watches a WIDTH-bit status bus (the LEDS by default) and records every value change into a DEPTH-entry FIFO, optionally with a cycle timestamp. Records drain through a valid/ready port, normally into the UART TX path, so LED traces from hardware runs can be read back on a host. It replaces bench-only print-on-change monitoring with logic that runs in simulation and on the FPGA.

---
 rtl/led_trace_capture.sv | 130 +++++++++++++
 1 files changed

// File: rtl/led_trace_capture.sv
// led_trace_capture: records every change of a status bus into a first-word fall-through FIFO
// drained over valid/ready. Define TRACE_TIMESTAMP_EN to store a cycle timestamp with each record.
module led_trace_capture #(
    parameter int WIDTH    = 6,
    parameter int DEPTH    = 16,
    parameter int TS_WIDTH = 16,
    parameter bit INVERT   = 1'b1
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [WIDTH-1:0]        SAMPLE,
    input  logic                    ENABLE,
    output logic                    OUT_VALID,
    input  logic                    OUT_READY,
    output logic [WIDTH-1:0]        OUT_DATA,
    output logic [TS_WIDTH-1:0]     OUT_TS,
    output logic [$clog2(DEPTH):0]  COUNT,
    output logic                    OVERFLOW,
    output logic [7:0]              DROPS,
    input  logic                    CLEAR_OVF
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
`ifdef TRACE_TIMESTAMP_EN
    localparam int EW = WIDTH + TS_WIDTH;
`else
    localparam int EW = WIDTH;
`endif

    logic [WIDTH-1:0] prev_q, prev_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             overflow_q, overflow_d;
    logic [7:0]       drops_q, drops_d;
    logic [EW-1:0]    mem_q [DEPTH];

    logic [WIDTH-1:0] rec_value;
    logic [EW-1:0]    wr_entry;
    logic [EW-1:0]    head;
    logic             empty, full;
    logic             change, do_pop, do_push, do_drop;

    // Wrap bit distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    assign rec_value = INVERT ? ~SAMPLE : SAMPLE;

`ifdef TRACE_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts_q, ts_d;

    always_comb begin
        ts_d = ts_q + TS_WIDTH'(1);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_d;
        end
    end

    assign wr_entry = {rec_value, ts_q};
    assign OUT_DATA = head[EW-1:TS_WIDTH];
    assign OUT_TS   = head[TS_WIDTH-1:0];
`else
    assign wr_entry = rec_value;
    assign OUT_DATA = head;
    assign OUT_TS   = '0;
`endif

    always_comb begin
        change     = !RESET && ENABLE && (SAMPLE != prev_q);
        do_pop     = !RESET && !empty && OUT_READY;
        // A full FIFO still accepts a record when the head leaves on the same edge.
        do_push    = change && (!full || do_pop);
        do_drop    = change && full && !do_pop;

        prev_d     = SAMPLE;
        wr_ptr_d   = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

        overflow_d = overflow_q;
        drops_d    = drops_q;
        if (do_drop) begin
            overflow_d = 1'b1;
            if (CLEAR_OVF) begin
                drops_d = 8'd1;
            end else if (drops_q != 8'hff) begin
                drops_d = drops_q + 8'd1;
            end
        end else if (CLEAR_OVF) begin
            overflow_d = 1'b0;
            drops_d    = 8'd0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            prev_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            drops_q    <= 8'd0;
        end else begin
            prev_q     <= prev_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            drops_q    <= drops_d;
        end
    end

    // NOTE: storage is not reset; the pointers alone define which entries are meaningful.
    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_entry;
        end
    end

    assign COUNT     = wr_ptr_q - rd_ptr_q;
    assign OUT_VALID = !empty;
    assign OVERFLOW  = overflow_q;
    assign DROPS     = drops_q;

endmodule
